dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single data memory (12-bit word address, 32-bit data, clocked on the inverted system clock) between the processor's memory stage and a secondary loader/debug master. The processor has priority; a bounded-wait counter guarantees the loader a slot after `MAX_WAIT` blocked cycles, stalling the processor for exactly one cycle. Read data from either master is registered and returned one cycle after the grant with a valid pulse. The block sits between the processor/loader and the dmem instance in the top level.

## Interface
- `ADDR_W`, 12, dmem word-address width
- `DATA_W`, 32, dmem data width
- `MAX_WAIT`, 4, loader blocked cycles before a forced grant (≥1)

- `clock`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-high
- `p_req`  in  1  processor access request
- `p_wren`  in  1  processor write (1) / read (0)
- `p_addr`  in  ADDR_W  processor address
- `p_data`  in  DATA_W  processor write data
- `p_stall`  out  1  processor request not granted this cycle
- `p_rvalid`  out  1  processor read data valid
- `p_q`  out  DATA_W  processor read data
- `d_req`, `d_wren`, `d_addr`, `d_data`  in  1/1/ADDR_W/DATA_W  loader request, same meaning
- `d_gnt`  out  1  loader granted this cycle
- `d_rvalid`  out  1  loader read data valid
- `d_q`  out  DATA_W  loader read data
- `address_dmem`  out  ADDR_W  to dmem
- `data`  out  DATA_W  to dmem write data
- `wren`  out  1  to dmem write enable
- `q_dmem`  in  DATA_W  from dmem

## Operation
- State: `wait_cnt` (0..MAX_WAIT), `rd_owner` (NONE/P/D), `p_q`, `d_q`, `p_rvalid`, `d_rvalid` registers.
- Grant (combinational from requests and `wait_cnt`):
  - `force = d_req & (wait_cnt == MAX_WAIT)`
  - `d_gnt = d_req & (~p_req | force)`
  - `p_gnt = p_req & ~d_gnt`; `p_stall = p_req & ~p_gnt`
- dmem mux: granted master's addr/data/wren drive `address_dmem`/`data`/`wren`; no grant → all zero, `wren`=0. At most one master drives per cycle.
- `wait_cnt` update: `d_req & ~d_gnt` → increment, saturate at MAX_WAIT; `d_gnt` or `~d_req` → 0. After a forced grant the processor wins the next contested cycle (no back-to-back forced grants).
- Read return: on rising edge ending grant cycle N of a read, `q_dmem` is captured into `p_q` or `d_q` of the owner; that master's `rvalid` is 1 for cycle N+1 only. Writes produce no `rvalid`. Non-owner `q` register holds its last value.
- Processor must hold request fields stable while `p_stall`=1; loader must hold while `d_gnt`=0.
- Simultaneous write and read to the same address across consecutive grants: read sees the earlier write (dmem ordering preserved; no reordering in block).

## Timing
- Reset (async, immediate): `wait_cnt`=0, `rd_owner`=NONE, `p_rvalid`=`d_rvalid`=0, `p_q`=`d_q`=0; combinational outputs follow reset state (`d_gnt`=`d_req & ~p_req`, `p_stall`=0 unless forced, never forced during reset).
- Reset mid-read: pending `rvalid` squashed; no data returned.
- Grant latency: 0 cycles (same-cycle combinational). Read latency: 1 cycle (grant cycle N → `rvalid` in N+1).
- Maximum loader wait under continuous `p_req`: MAX_WAIT cycles, granted in cycle MAX_WAIT+1.
- Processor stall per forced grant: exactly 1 cycle.
- Throughput: one access per cycle total; back-to-back reads by same master give `rvalid` every cycle.

## Test plan
- Reset with `d_req`=1, `p_req`=0 → `d_gnt`=1, `wren`=0 for read, outputs/q registers 0 during reset; after release read addr 5 holding 0xDEADBEEF → `d_rvalid`=1, `d_q`=0xDEADBEEF next cycle.
- Processor write 0x12345678 to addr 0x00A, next cycle read 0x00A → `wren`=1 in first cycle, `p_rvalid`=1 with `p_q`=0x12345678 one cycle after read grant, `p_stall`=0 throughout.
- Continuous `p_req` and `d_req` with MAX_WAIT=4 → `p_stall`=0 cycles 1-4, cycle 5 `d_gnt`=1 and `p_stall`=1, cycle 6 processor granted, `wait_cnt` restarts from 0; pattern repeats every 5 cycles.
- `d_req` drops after 2 blocked cycles and reasserts → `wait_cnt` cleared; loader again waits full 4 cycles.
- Assert `reset` in the cycle after a loader read grant → `d_rvalid` stays 0, `d_q`=0.
- No requests → `address_dmem`=0, `data`=0, `wren`=0, both `rvalid`=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the processor/loader masters, the arbiter and the data memory.
// The arbiter attaches through the slave modport; the master modport is the masters' and memory's view.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              p_req;
   logic              p_wren;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_data;
   logic              p_stall;
   logic              p_rvalid;
   logic [DATA_W-1:0] p_q;

   logic              d_req;
   logic              d_wren;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_data;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_q;

   logic [ADDR_W-1:0] address_dmem;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic [DATA_W-1:0] q_dmem;

   modport slave (
      input  p_req, p_wren, p_addr, p_data,
      input  d_req, d_wren, d_addr, d_data,
      input  q_dmem,
      output p_stall, p_rvalid, p_q,
      output d_gnt, d_rvalid, d_q,
      output address_dmem, data, wren
   );

   modport master (
      output p_req, p_wren, p_addr, p_data,
      output d_req, d_wren, d_addr, d_data,
      output q_dmem,
      input  p_stall, p_rvalid, p_q,
      input  d_gnt, d_rvalid, d_q,
      input  address_dmem, data, wren
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the processor (priority) and a loader/debug master.
// The loader is guaranteed a slot after MAX_WAIT blocked cycles; read data returns one cycle after grant.
module dmem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input logic           clock,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_P    = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   logic [CW-1:0]     wait_cnt_r;
   logic [CW-1:0]     wait_cnt_nxt_s;
   owner_t            rd_owner_r;
   owner_t            rd_owner_nxt_s;
   logic [DATA_W-1:0] p_q_r;
   logic [DATA_W-1:0] d_q_r;
   logic              force_s;
   logic              d_gnt_s;
   logic              p_gnt_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;
   logic              wren_s;

   // grant decision: processor first unless the loader has waited MAX_WAIT cycles
   always_comb begin
      force_s = bus.d_req & (wait_cnt_r == MAX_CNT);
      d_gnt_s = bus.d_req & (~bus.p_req | force_s);
      p_gnt_s = bus.p_req & ~d_gnt_s;
   end

   // memory-side mux; idle bus is driven to all zeros
   always_comb begin
      addr_s = {ADDR_W{1'b0}};
      data_s = {DATA_W{1'b0}};
      wren_s = 1'b0;
      if (d_gnt_s) begin
         addr_s = bus.d_addr;
         data_s = bus.d_data;
         wren_s = bus.d_wren;
      end else if (p_gnt_s) begin
         addr_s = bus.p_addr;
         data_s = bus.p_data;
         wren_s = bus.p_wren;
      end else begin
         wren_s = 1'b0;
      end
   end

   // next state: bounded-wait counter and owner of the read in flight
   always_comb begin
      wait_cnt_nxt_s = {CW{1'b0}};
      rd_owner_nxt_s = OWN_NONE;
      if (d_gnt_s || !bus.d_req) begin
         wait_cnt_nxt_s = {CW{1'b0}};
      end else if (wait_cnt_r == MAX_CNT) begin
         wait_cnt_nxt_s = MAX_CNT;
      end else begin
         wait_cnt_nxt_s = wait_cnt_r + CW'(1);
      end
      if (d_gnt_s && !bus.d_wren) begin
         rd_owner_nxt_s = OWN_D;
      end else if (p_gnt_s && !bus.p_wren) begin
         rd_owner_nxt_s = OWN_P;
      end else begin
         rd_owner_nxt_s = OWN_NONE;
      end
   end

   // state registers; memory data is stable here because dmem updates on the falling edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt_r <= {CW{1'b0}};
         rd_owner_r <= OWN_NONE;
         p_q_r      <= {DATA_W{1'b0}};
         d_q_r      <= {DATA_W{1'b0}};
      end else begin
         wait_cnt_r <= wait_cnt_nxt_s;
         rd_owner_r <= rd_owner_nxt_s;
         case (rd_owner_nxt_s)
            OWN_P:   p_q_r <= bus.q_dmem;
            OWN_D:   d_q_r <= bus.q_dmem;
            default: ;
         endcase
      end
   end

   assign bus.d_gnt        = d_gnt_s;
   assign bus.p_stall      = bus.p_req & ~p_gnt_s;
   assign bus.address_dmem = addr_s;
   assign bus.data         = data_s;
   assign bus.wren         = wren_s;
   assign bus.p_rvalid     = (rd_owner_r == OWN_P);
   assign bus.d_rvalid     = (rd_owner_r == OWN_D);
   assign bus.p_q          = p_q_r;
   assign bus.d_q          = d_q_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a falling-edge memory model and a read-return scoreboard.
module tb_dmem_arbiter;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        p_req;
      logic        p_wren;
      logic [11:0] p_addr;
      logic [31:0] p_data;
      logic        d_req;
      logic        d_wren;
      logic [11:0] d_addr;
      logic [31:0] d_data;
      logic        e_stall;
      logic        e_dgnt;
   } vec_t;

   typedef struct {
      logic        prv;
      logic        drv;
      logic [31:0] pq;
      logic [31:0] dq;
   } exp_t;

   logic [31:0] mem [0:4095];
   logic [31:0] ref_mem [0:4095];
   exp_t        sb [$];
   vec_t        vecs [$];
   logic [31:0] exp_pq;
   logic [31:0] exp_dq;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // data memory on the inverted clock
   always @(negedge clock) begin
      if (reset) mem[5] <= 32'hDEADBEEF;
      else if (bus.wren) mem[bus.address_dmem] <= bus.data;
      bus.q_dmem <= mem[bus.address_dmem];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                               input logic dr, input logic dw, input logic [11:0] da, input logic [31:0] dd,
                               input logic es, input logic eg);
      vec_t v;
      v.p_req = pr; v.p_wren = pw; v.p_addr = pa; v.p_data = pd;
      v.d_req = dr; v.d_wren = dw; v.d_addr = da; v.d_data = dd;
      v.e_stall = es; v.e_dgnt = eg;
      return v;
   endfunction

   task automatic run_cycle(input vec_t v, input string nm);
      exp_t        e;
      exp_t        got;
      logic [11:0] ea;
      logic [31:0] ed;
      logic        ew;
      bus.p_req = v.p_req; bus.p_wren = v.p_wren; bus.p_addr = v.p_addr; bus.p_data = v.p_data;
      bus.d_req = v.d_req; bus.d_wren = v.d_wren; bus.d_addr = v.d_addr; bus.d_data = v.d_data;
      ea = 12'h000; ed = 32'h0; ew = 1'b0; e.prv = 1'b0; e.drv = 1'b0;
      if (v.e_dgnt) begin
         ea = v.d_addr; ed = v.d_data; ew = v.d_wren;
         if (v.d_wren) ref_mem[v.d_addr] = v.d_data;
         else begin exp_dq = ref_mem[v.d_addr]; e.drv = 1'b1; end
      end else if (v.p_req && !v.e_stall) begin
         ea = v.p_addr; ed = v.p_data; ew = v.p_wren;
         if (v.p_wren) ref_mem[v.p_addr] = v.p_data;
         else begin exp_pq = ref_mem[v.p_addr]; e.prv = 1'b1; end
      end
      e.pq = exp_pq; e.dq = exp_dq;
      sb.push_back(e);
      #1;
      chk({nm, " p_stall"}, {31'b0, bus.p_stall}, {31'b0, v.e_stall});
      chk({nm, " d_gnt"}, {31'b0, bus.d_gnt}, {31'b0, v.e_dgnt});
      chk({nm, " wren"}, {31'b0, bus.wren}, {31'b0, ew});
      chk({nm, " address_dmem"}, {20'b0, bus.address_dmem}, {20'b0, ea});
      chk({nm, " data"}, bus.data, ed);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         chk({nm, " scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         chk({nm, " p_rvalid"}, {31'b0, bus.p_rvalid}, {31'b0, got.prv});
         chk({nm, " d_rvalid"}, {31'b0, bus.d_rvalid}, {31'b0, got.drv});
         chk({nm, " p_q"}, bus.p_q, got.pq);
         chk({nm, " d_q"}, bus.d_q, got.dq);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      exp_pq = 32'h0; exp_dq = 32'h0;
      ref_mem[5] = 32'hDEADBEEF;

      // reset with a loader read pending
      reset = 1'b1;
      bus.p_req = 1'b0; bus.p_wren = 1'b0; bus.p_addr = 12'h000; bus.p_data = 32'h0;
      bus.d_req = 1'b1; bus.d_wren = 1'b0; bus.d_addr = 12'h005; bus.d_data = 32'h0;
      #3;
      chk("rst d_gnt", {31'b0, bus.d_gnt}, 32'd1);
      chk("rst p_stall", {31'b0, bus.p_stall}, 32'd0);
      chk("rst wren", {31'b0, bus.wren}, 32'd0);
      @(posedge clock); #1;
      chk("rst d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
      chk("rst p_rvalid", {31'b0, bus.p_rvalid}, 32'd0);
      chk("rst d_q", bus.d_q, 32'h0);
      chk("rst p_q", bus.p_q, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;

      //            p_req wr  addr     data           d_req wr  addr     data          stall gnt
      vecs.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h005, 32'h0,        1'b0, 1'b1)); // loader read 5
      vecs.push_back(mk(1'b1, 1'b1, 12'h00A, 32'h12345678, 1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0)); // proc write
      vecs.push_back(mk(1'b1, 1'b0, 12'h00A, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0)); // proc read back
      vecs.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0)); // idle
      for (int i = 0; i < 10; i++) begin
         // contested: forced loader grant every fifth cycle
         vecs.push_back(mk(1'b1, 1'b0, 12'h00A, 32'h0, 1'b1, 1'b0, 12'h005, 32'h0,
                           (i % 5 == 4) ? 1'b1 : 1'b0, (i % 5 == 4) ? 1'b1 : 1'b0));
      end
      vecs.push_back(mk(1'b1, 1'b0, 12'h00A, 32'h0, 1'b1, 1'b0, 12'h005, 32'h0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 12'h00A, 32'h0, 1'b1, 1'b0, 12'h005, 32'h0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 12'h00A, 32'h0, 1'b0, 1'b0, 12'h005, 32'h0, 1'b0, 1'b0)); // loader drops
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(mk(1'b1, 1'b0, 12'h00A, 32'h0, 1'b1, 1'b0, 12'h005, 32'h0,
                           (i == 4) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0));
      end
      vecs.push_back(mk(1'b1, 1'b0, 12'h00A, 32'h0, 1'b1, 1'b1, 12'h020, 32'hCAFEF00D, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h020, 32'hCAFEF00D, 1'b0, 1'b1)); // loader write
      vecs.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0,        1'b0, 1'b1)); // loader read
      vecs.push_back(mk(1'b1, 1'b1, 12'h030, 32'h00000077, 1'b1, 1'b0, 12'h005, 32'h0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 12'h030, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0));

      foreach (vecs[i]) run_cycle(vecs[i], $sformatf("v%0d", i));

      // reset in the cycle after a loader read grant squashes the return
      bus.p_req = 1'b0; bus.d_req = 1'b1; bus.d_wren = 1'b0; bus.d_addr = 12'h020; bus.d_data = 32'h0;
      #1;
      chk("rr d_gnt", {31'b0, bus.d_gnt}, 32'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      bus.d_req = 1'b0;
      #1;
      chk("rr d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
      chk("rr d_q", bus.d_q, 32'h0);
      chk("rr p_q", bus.p_q, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      exp_pq = 32'h0; exp_dq = 32'h0;
      run_cycle(mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0), "post_rst_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
